// File: rtl/regfile_pkg.sv
// Shared types and sizes for the register-file write-back path.
package regfile_pkg;
    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 4;
    localparam int NUM_REGS = 2 ** ADDR_W;

    typedef struct packed {
        logic [ADDR_W-1:0]        rd;
        logic signed [DATA_W-1:0] data;
    } wb_entry_t;
endpackage

// File: rtl/wb_fifo_2w1r.sv
// Two-push, one-pop synchronous FIFO of write-back entries.
// Entry A is always older than entry B; no write-to-read pass-through.
module wb_fifo_2w1r
    import regfile_pkg::*;
#(
    parameter int DEPTH = 4
)
(
    input  logic                     CLK,
    input  logic                     reset,
    input  logic                     push_a,
    input  wb_entry_t                entry_a,
    input  logic                     push_b,
    input  wb_entry_t                entry_b,
    input  logic                     pop,
    output wb_entry_t                head,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_entry_t        mem_reg [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] wr_ptr_inc;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;

    logic      w0_en;
    logic      w1_en;
    wb_entry_t w0_data;

    // A lone B push takes the first free slot so the array stays dense.
    assign w0_en      = push_a || push_b;
    assign w1_en      = push_a && push_b;
    assign w0_data    = push_a ? entry_a : entry_b;
    assign wr_ptr_inc = wr_ptr_reg + PTR_W'(1);

    always_ff @(posedge CLK) begin
        if (w0_en)
            mem_reg[wr_ptr_reg] <= w0_data;
        if (w1_en)
            mem_reg[wr_ptr_inc] <= entry_b;
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(w0_en) + PTR_W'(w1_en);
            rd_ptr_reg <= rd_ptr_reg + PTR_W'(pop);
            count_reg  <= count_reg + CNT_W'(w0_en) + CNT_W'(w1_en) - CNT_W'(pop);
        end
    end

    assign head  = mem_reg[rd_ptr_reg];
    assign count = count_reg;
endmodule

// File: rtl/regfile_writeback_queue.sv
// Merges MEM and ALU write-back results into one in-order register-file write stream
// and tracks per-register pending writes for decode stall checks.
module regfile_writeback_queue
    import regfile_pkg::*;
#(
    parameter int DEPTH = 4
)
(
    input  logic                   CLK,
    input  logic                   reset,
    input  logic                   mem_valid,
    input  logic [ADDR_W-1:0]      mem_rd,
    input  logic [DATA_W-1:0]      mem_data,
    output logic                   mem_ready,
    input  logic                   alu_valid,
    input  logic [ADDR_W-1:0]      alu_rd,
    input  logic [DATA_W-1:0]      alu_data,
    output logic                   alu_ready,
    output logic                   regWrite,
    output logic [ADDR_W-1:0]      rd,
    output logic [DATA_W-1:0]      dataWrite,
    input  logic [ADDR_W-1:0]      rs0,
    input  logic [ADDR_W-1:0]      rs1,
    output logic                   rs0_busy,
    output logic                   rs1_busy,
    output logic [NUM_REGS-1:0]    busy,
    output logic [$clog2(DEPTH):0] q_count
);
    localparam int CNT_W  = $clog2(DEPTH) + 1;
    localparam int PEND_W = $clog2(DEPTH + 1) + 1;

    logic [CNT_W-1:0]  free_slots;
    logic              mem_push;
    logic              alu_push;
    logic              pop;
    wb_entry_t         head;
    wb_entry_t         mem_entry;
    wb_entry_t         alu_entry;

    logic              wb_en_reg;
    logic [ADDR_W-1:0] wb_rd_reg;
    logic [DATA_W-1:0] wb_data_reg;

    // Readiness looks only at the registered count; a pop this cycle gives no credit.
    assign free_slots = CNT_W'(DEPTH) - q_count;
    assign mem_ready  = !reset && (free_slots >= CNT_W'(1));
    assign alu_ready  = !reset && (mem_valid ? (free_slots >= CNT_W'(2))
                                             : (free_slots >= CNT_W'(1)));

    // Writes to r0 complete the handshake but are dropped here.
    assign mem_push  = mem_valid && mem_ready && (mem_rd != '0);
    assign alu_push  = alu_valid && alu_ready && (alu_rd != '0);
    assign mem_entry = '{rd: mem_rd, data: mem_data};
    assign alu_entry = '{rd: alu_rd, data: alu_data};
    assign pop       = (q_count != '0);

    wb_fifo_2w1r #(.DEPTH(DEPTH)) u_fifo (
        .CLK     (CLK),
        .reset   (reset),
        .push_a  (mem_push),
        .entry_a (mem_entry),
        .push_b  (alu_push),
        .entry_b (alu_entry),
        .pop     (pop),
        .head    (head),
        .count   (q_count)
    );

    always_ff @(posedge CLK) begin
        if (reset) begin
            wb_en_reg   <= 1'b0;
            wb_rd_reg   <= '0;
            wb_data_reg <= '0;
        end else if (pop) begin
            wb_en_reg   <= 1'b1;
            wb_rd_reg   <= head.rd;
            wb_data_reg <= head.data;
        end else begin
            wb_en_reg   <= 1'b0;
        end
    end

    assign regWrite  = wb_en_reg;
    assign rd        = wb_rd_reg;
    assign dataWrite = wb_data_reg;

    // Pending count covers queued entries plus the one held in the output register.
    genvar gi;
    assign busy[0] = 1'b0;
    generate
        for (gi = 1; gi < NUM_REGS; gi++) begin : g_pend
            logic [PEND_W-1:0] cnt_reg;
            logic [PEND_W-1:0] cnt_next;
            logic [PEND_W-1:0] inc;
            logic [PEND_W-1:0] dec;

            always_comb begin
                inc      = PEND_W'(mem_push && (mem_rd == ADDR_W'(gi)))
                         + PEND_W'(alu_push && (alu_rd == ADDR_W'(gi)));
                dec      = PEND_W'(wb_en_reg && (wb_rd_reg == ADDR_W'(gi)));
                cnt_next = cnt_reg + inc - dec;
            end

            always_ff @(posedge CLK) begin
                if (reset)
                    cnt_reg <= '0;
                else
                    cnt_reg <= cnt_next;
            end

            assign busy[gi] = (cnt_reg != '0);
        end
    endgenerate

    assign rs0_busy = busy[rs0];
    assign rs1_busy = busy[rs1];
endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Randomized and directed bench for regfile_writeback_queue against a queue-based model.
module tb_regfile_writeback_queue;
    import regfile_pkg::*;

    localparam int DEPTH = 4;

    logic        CLK = 1'b0;
    logic        reset;
    logic        mem_valid, alu_valid;
    logic [3:0]  mem_rd, alu_rd, rs0, rs1;
    logic [15:0] mem_data, alu_data;
    logic        mem_ready, alu_ready, regWrite, rs0_busy, rs1_busy;
    logic [3:0]  rd;
    logic [15:0] dataWrite;
    logic [15:0] busy;
    logic [2:0]  q_count;

    always #5 CLK = ~CLK;

    regfile_writeback_queue #(.DEPTH(DEPTH)) dut (
        .CLK       (CLK),
        .reset     (reset),
        .mem_valid (mem_valid),
        .mem_rd    (mem_rd),
        .mem_data  (mem_data),
        .mem_ready (mem_ready),
        .alu_valid (alu_valid),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .alu_ready (alu_ready),
        .regWrite  (regWrite),
        .rd        (rd),
        .dataWrite (dataWrite),
        .rs0       (rs0),
        .rs1       (rs1),
        .rs0_busy  (rs0_busy),
        .rs1_busy  (rs1_busy),
        .busy      (busy),
        .q_count   (q_count)
    );

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Behavioural model: queue of accepted entries, one output slot, per-register pending counts.
    wb_entry_t   m_q[$];
    bit          m_out_v   = 1'b0;
    logic [3:0]  m_out_rd  = '0;
    logic [15:0] m_out_data = '0;
    int          m_pend[16];
    bit          m_live    = 1'b0;
    bit          m_mem_acc = 1'b0;
    bit          m_alu_acc = 1'b0;
    wb_entry_t   dut_log[$];

    always @(posedge CLK) begin
        int free;
        wb_entry_t e;
        if (reset) begin
            m_q.delete();
            m_out_v    = 1'b0;
            m_out_rd   = '0;
            m_out_data = '0;
            for (int r = 0; r < 16; r++) m_pend[r] = 0;
            m_mem_acc  = 1'b0;
            m_alu_acc  = 1'b0;
            m_live     = 1'b1;
        end else if (m_live) begin
            free      = DEPTH - m_q.size();
            m_mem_acc = mem_valid && (free >= 1);
            m_alu_acc = alu_valid && (mem_valid ? (free >= 2) : (free >= 1));
            if (m_out_v) m_pend[m_out_rd]--;
            if (m_q.size() > 0) begin
                e          = m_q.pop_front();
                m_out_v    = 1'b1;
                m_out_rd   = e.rd;
                m_out_data = e.data;
            end else begin
                m_out_v = 1'b0;
            end
            if (m_mem_acc && mem_rd != 4'd0) begin
                m_q.push_back('{rd: mem_rd, data: mem_data});
                m_pend[mem_rd]++;
            end
            if (m_alu_acc && alu_rd != 4'd0) begin
                m_q.push_back('{rd: alu_rd, data: alu_data});
                m_pend[alu_rd]++;
            end
        end
    end

    // Compare process: every cycle once the model has seen reset.
    always @(negedge CLK) begin
        logic [15:0] exp_busy;
        int free;
        if (m_live) begin
            free = DEPTH - m_q.size();
            for (int r = 0; r < 16; r++) exp_busy[r] = (m_pend[r] != 0);
            chk("mem_ready", 32'(mem_ready), 32'(!reset && free >= 1));
            chk("alu_ready", 32'(alu_ready), 32'(!reset && (mem_valid ? free >= 2 : free >= 1)));
            chk("regWrite",  32'(regWrite),  32'(m_out_v));
            chk("rd",        32'(rd),        32'(m_out_rd));
            chk("dataWrite", 32'(dataWrite), 32'(m_out_data));
            chk("q_count",   32'(q_count),   32'(m_q.size()));
            chk("busy",      32'(busy),      32'(exp_busy));
            chk("rs0_busy",  32'(rs0_busy),  32'(m_pend[rs0] != 0));
            chk("rs1_busy",  32'(rs1_busy),  32'(m_pend[rs1] != 0));
            if (regWrite === 1'b1) dut_log.push_back('{rd: rd, data: dataWrite});
        end
    end

    task automatic step();
        @(posedge CLK);
        #2;
    endtask

    initial begin
        int start;
        reset = 1'b1;
        mem_valid = 1'b0; alu_valid = 1'b0;
        mem_rd = '0; alu_rd = '0; mem_data = '0; alu_data = '0;
        rs0 = '0; rs1 = '0;
        repeat (2) step();
        chk("reset_regWrite", 32'(regWrite), 32'd0);
        chk("reset_q_count", 32'(q_count), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        step();

        // Single ALU write
        alu_valid = 1'b1; alu_rd = 4'd5; alu_data = 16'h1234;
        #1 chk("t1_alu_ready", 32'(alu_ready), 32'd1);
        step();
        alu_valid = 1'b0;
        chk("t1_busy5_e1", 32'(busy[5]), 32'd1);
        chk("t1_regWrite_e1", 32'(regWrite), 32'd0);
        chk("t1_q_count_e1", 32'(q_count), 32'd1);
        step();
        chk("t1_regWrite_e2", 32'(regWrite), 32'd1);
        chk("t1_rd_e2", 32'(rd), 32'd5);
        chk("t1_data_e2", 32'(dataWrite), 32'h1234);
        chk("t1_busy5_e2", 32'(busy[5]), 32'd1);
        step();
        chk("t1_regWrite_e3", 32'(regWrite), 32'd0);
        chk("t1_busy_e3", 32'(busy), 32'd0);

        // Dual accept, same destination
        mem_valid = 1'b1; mem_rd = 4'd3; mem_data = 16'h00AA;
        alu_valid = 1'b1; alu_rd = 4'd3; alu_data = 16'h00BB;
        #1 chk("t2_alu_ready", 32'(alu_ready), 32'd1);
        step();
        mem_valid = 1'b0; alu_valid = 1'b0;
        chk("t2_q_count", 32'(q_count), 32'd2);
        step();
        chk("t2_first_rd", 32'(rd), 32'd3);
        chk("t2_first_data", 32'(dataWrite), 32'h00AA);
        step();
        chk("t2_second_data", 32'(dataWrite), 32'h00BB);
        chk("t2_busy3_mid", 32'(busy[3]), 32'd1);
        step();
        chk("t2_busy3_done", 32'(busy[3]), 32'd0);

        // Six back-to-back ALU writes, commit order checked against literals
        start = dut_log.size();
        for (int i = 0; i < 6; i++) begin
            int tries;
            alu_valid = 1'b1; alu_rd = 4'(i + 1); alu_data = 16'h0100 + 16'(i + 1);
            tries = 0;
            do begin step(); tries++; end while (!m_alu_acc && tries < 20);
            n_checks++;
            if (!m_alu_acc) begin
                n_fail++;
                $display("FAIL t3_accept_timeout: write %0d not accepted in %0d cycles", i, tries);
            end
        end
        alu_valid = 1'b0;
        repeat (5) step();
        chk("t3_commit_count", 32'(dut_log.size() - start), 32'd6);
        for (int i = 0; i < 6; i++) begin
            if (start + i < dut_log.size()) begin
                chk("t3_order_rd", 32'(dut_log[start + i].rd), 32'(i + 1));
                chk("t3_order_data", 32'(dut_log[start + i].data), 32'h0101 + 32'(i));
            end
        end

        // rd == 0 is handshaken but dropped
        alu_valid = 1'b1; alu_rd = 4'd0; alu_data = 16'hFFFF;
        #1 chk("t4_alu_ready", 32'(alu_ready), 32'd1);
        step();
        alu_valid = 1'b0;
        chk("t4_q_count", 32'(q_count), 32'd0);
        chk("t4_busy", 32'(busy), 32'd0);
        step();
        chk("t4_regWrite", 32'(regWrite), 32'd0);

        // Reset with three entries queued
        mem_valid = 1'b1; mem_rd = 4'd1; mem_data = 16'h0011;
        alu_valid = 1'b1; alu_rd = 4'd2; alu_data = 16'h0022;
        step();
        mem_rd = 4'd4; mem_data = 16'h0044; alu_rd = 4'd6; alu_data = 16'h0066;
        step();
        mem_valid = 1'b0; alu_valid = 1'b0;
        chk("t5_q_count_pre", 32'(q_count), 32'd3);
        reset = 1'b1; mem_valid = 1'b1; mem_rd = 4'd9;
        #1 chk("t5_mem_ready_rst", 32'(mem_ready), 32'd0);
        chk("t5_alu_ready_rst", 32'(alu_ready), 32'd0);
        step();
        chk("t5_regWrite", 32'(regWrite), 32'd0);
        chk("t5_q_count", 32'(q_count), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        reset = 1'b0; mem_valid = 1'b0;
        #1 chk("t5_mem_ready_back", 32'(mem_ready), 32'd1);
        chk("t5_alu_ready_back", 32'(alu_ready), 32'd1);
        step();

        // Decode stall query
        rs0 = 4'd7; rs1 = 4'd2;
        alu_valid = 1'b1; alu_rd = 4'd7; alu_data = 16'h0777;
        step();
        alu_valid = 1'b0;
        #1 chk("t6_rs0_busy", 32'(rs0_busy), 32'd1);
        chk("t6_rs1_busy", 32'(rs1_busy), 32'd0);
        step();
        chk("t6_rs0_busy_out", 32'(rs0_busy), 32'd1);
        step();
        chk("t6_rs0_busy_done", 32'(rs0_busy), 32'd0);
        chk("t6_rs1_busy_done", 32'(rs1_busy), 32'd0);

        // Randomized traffic; sources hold until accepted
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (!mem_valid || m_mem_acc) begin
                mem_valid = ($urandom_range(0, 99) < 60);
                mem_rd    = 4'($urandom_range(0, 15));
                mem_data  = 16'($urandom);
            end
            if (!alu_valid || m_alu_acc) begin
                alu_valid = ($urandom_range(0, 99) < 70);
                alu_rd    = 4'($urandom_range(0, 15));
                alu_data  = 16'($urandom);
            end
            rs0   = 4'($urandom_range(0, 15));
            rs1   = 4'($urandom_range(0, 15));
            reset = ($urandom_range(0, 199) == 0);
            step();
        end
        reset = 1'b0; mem_valid = 1'b0; alu_valid = 1'b0;
        repeat (8) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
